// File: rtl/bram_port_ctrl_if.sv
// Client-side request/response bus for bram_port_ctrl.
// The master modport is the client issuing requests and taking responses;
// the slave modport is the controller.
interface bram_port_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/bram_port_ctrl.sv
// Single-port BRAM controller: zeroes the whole RAM after reset, then serves
// client reads/writes with a credit-limited 2-entry response FIFO so that
// read data is never lost while the response channel is stalled.
module bram_port_ctrl #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 512,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bram_port_ctrl_if.slave       bus,
    output logic                  init_done,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t                r_state;
    state_t                w_nextState;
    logic [ADDR_W-1:0]     r_sweep;

    logic [DATA_WIDTH-1:0] r_fifo [2];
    logic                  r_wrPtr;
    logic                  r_rdPtr;
    logic [1:0]            r_count;
    logic                  r_inFlight;

    logic [1:0]            w_credits;
    logic                  w_reqReady;
    logic                  w_accept;
    logic                  w_readAccept;
    logic                  w_fifoEmpty;
    logic                  w_rspValid;
    logic                  w_pop;
    logic                  w_fifoPop;
    logic                  w_fifoPush;

    // Credits count every read that is accepted but not yet consumed; ready
    // depends only on flops so there is no path from rsp_ready or req_valid.
    assign w_credits    = r_count + {1'b0, r_inFlight};
    assign w_reqReady   = (r_state == S_RUN) && (w_credits < 2'd2);
    assign w_accept     = bus.req_valid && w_reqReady;
    assign w_readAccept = w_accept && !bus.req_we;

    // The arriving read word bypasses the FIFO only when the FIFO is empty;
    // it is parked in the FIFO unless it is consumed in that same cycle.
    assign w_fifoEmpty  = (r_count == 2'd0);
    assign w_rspValid   = !w_fifoEmpty || r_inFlight;
    assign w_pop        = w_rspValid && bus.rsp_ready;
    assign w_fifoPop    = w_pop && !w_fifoEmpty;
    assign w_fifoPush   = r_inFlight && !(w_fifoEmpty && bus.rsp_ready);

    assign bus.req_ready = w_reqReady;
    assign bus.rsp_valid = w_rspValid;
    assign bus.rsp_data  = !w_fifoEmpty ? r_fifo[r_rdPtr] :
                           (r_inFlight  ? ram_data_out : '0);
    assign init_done     = (r_state == S_RUN);

    // State register and sweep counter that walks every address once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sweep <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_INIT) begin
                r_sweep <= (r_sweep == LAST_ADDR) ? '0 : r_sweep + 1'b1;
            end
        end
    end

    // Next-state decode and RAM port drive: zero-fill sweep or client pass-through.
    always_comb begin
        w_nextState = r_state;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_data_in = '0;
        case (r_state)
            S_IDLE: begin
                w_nextState = S_INIT;
            end
            S_INIT: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = r_sweep;
                if (r_sweep == LAST_ADDR) begin
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    ram_en      = 1'b1;
                    ram_we      = bus.req_we;
                    ram_addr    = bus.req_addr;
                    ram_data_in = bus.req_wdata;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Response FIFO storage, pointers, occupancy and the read-in-flight flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo[i] <= '0;
            end
            r_wrPtr    <= 1'b0;
            r_rdPtr    <= 1'b0;
            r_count    <= 2'd0;
            r_inFlight <= 1'b0;
        end else begin
            r_inFlight <= w_readAccept;
            if (w_fifoPush) begin
                r_fifo[r_wrPtr] <= ram_data_out;
                r_wrPtr         <= ~r_wrPtr;
            end
            if (w_fifoPop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_fifoPush, w_fifoPop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_port_ctrl.sv
// Self-checking bench for bram_port_ctrl (DEPTH=8, DATA_WIDTH=32).
// A behavioural write-first RAM sits on the RAM port; a reference memory plus
// an expected-response queue in the monitor predicts every response.
module tb_bram_port_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk;
    logic          rst_n;
    logic          init_done;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;

    bram_port_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    bram_port_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .init_done    (init_done),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    int            checks = 0;
    int            errors = 0;
    logic          monEn = 1'b0;
    logic          rndReady = 1'b0;
    logic          forcedReady = 1'b0;
    logic [DW-1:0] ramMem [DEPTH];
    logic [DW-1:0] refMem [DEPTH];
    logic [DW-1:0] expQ [$];

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural synchronous write-first RAM; reset fills it with garbage so
    // only the controller's sweep can make it read back as zero.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ramMem[i] <= $urandom;
            end
            ram_data_out <= $urandom;
        end else if (ram_en) begin
            if (ram_we) begin
                ramMem[ram_addr] <= ram_data_in;
                ram_data_out     <= ram_data_in;
            end else begin
                ram_data_out <= ramMem[ram_addr];
            end
        end
    end

    // Response-side backpressure: either random per cycle or a fixed level.
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.rsp_ready = rndReady ? 1'($urandom_range(0, 1)) : forcedReady;
        end
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard: the number of outstanding reads predicts ready and
    // valid; the queue head predicts rsp_data every cycle it is presented.
    initial begin
        forever begin
            @(negedge clk);
            if (!monEn) begin
                expQ.delete();
                for (int i = 0; i < DEPTH; i++) begin
                    refMem[i] = '0;
                end
            end else begin
                checkOutput("req_ready", DW'(bus.req_ready), DW'(expQ.size() < 2));
                checkOutput("rsp_valid", DW'(bus.rsp_valid), DW'(expQ.size() > 0));
                if (bus.rsp_valid && expQ.size() > 0) begin
                    checkOutput("rsp_data", bus.rsp_data, expQ[0]);
                    if (bus.rsp_ready) begin
                        void'(expQ.pop_front());
                    end
                end
                if (bus.req_valid && bus.req_ready) begin
                    if (bus.req_we) begin
                        refMem[bus.req_addr] = bus.req_wdata;
                    end else begin
                        expQ.push_back(refMem[bus.req_addr]);
                    end
                end
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rsp_valid"}, DW'(bus.rsp_valid), '0);
        checkOutput({tag, "_req_ready"}, DW'(bus.req_ready), '0);
        checkOutput({tag, "_init_done"}, DW'(init_done), '0);
        checkOutput({tag, "_ram_en"}, DW'(ram_en), '0);
        checkOutput({tag, "_ram_we"}, DW'(ram_we), '0);
        checkOutput({tag, "_ram_addr"}, DW'(ram_addr), '0);
        checkOutput({tag, "_ram_data_in"}, ram_data_in, '0);
        checkOutput({tag, "_rsp_data"}, bus.rsp_data, '0);
    endtask

    // Releases reset and follows the IDLE cycle and the zero-fill sweep while
    // a bogus request is held to show it is ignored. If abortAt >= 0, reset
    // is reasserted mid-sweep at that counter value and the task returns.
    task automatic checkSweep(input int abortAt);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = 32'hA5A5_0000 | DW'($urandom_range(1, 255));
        @(negedge clk);
        checkOutput("idle_ram_en", DW'(ram_en), '0);
        checkOutput("idle_req_ready", DW'(bus.req_ready), '0);
        checkOutput("idle_init_done", DW'(init_done), '0);
        checkOutput("idle_rsp_valid", DW'(bus.rsp_valid), '0);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            checkOutput("init_ram_en", DW'(ram_en), 1);
            checkOutput("init_ram_we", DW'(ram_we), 1);
            checkOutput("init_ram_addr", DW'(ram_addr), DW'(i));
            checkOutput("init_ram_data_in", ram_data_in, '0);
            checkOutput("init_req_ready", DW'(bus.req_ready), '0);
            checkOutput("init_done_low", DW'(init_done), '0);
            checkOutput("init_rsp_valid", DW'(bus.rsp_valid), '0);
            if (i == abortAt) begin
                #2;
                rst_n         = 1'b0;
                bus.req_valid = 1'b0;
                #1;
                checkResetOutputs("init_reset");
                return;
            end
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("run_init_done", DW'(init_done), 1);
        checkOutput("run_req_ready", DW'(bus.req_ready), 1);
        checkOutput("run_ram_en_idle", DW'(ram_en), '0);
        checkOutput("run_rsp_valid", DW'(bus.rsp_valid), '0);
    endtask

    // Presents one request (called just after a rising edge) and holds it
    // until accepted; returns just after the accepting edge.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata);
        int waited;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            waited++;
            if (waited > 100) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout: got no acceptance in %0d cycles, expected acceptance", waited);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleReq();
        bus.req_valid = 1'b0;
    endtask

    // Main sequence: directed scenarios, random traffic, then reset cases.
    initial begin
        rst_n         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        #1;
        rst_n = 1'b0;
        #2;
        checkResetOutputs("por");
        checkSweep(-1);
        monEn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] write then read back addr 3");
        forcedReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1'b1, 3'd3, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 3'd3, '0);
        idleReq();
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] three reads under a stalled response channel");
        forcedReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'd1, '0);
        applyStimulus(1'b0, 3'd2, '0);
        fork
            applyStimulus(1'b0, 3'd3, '0);
            begin
                repeat (4) @(posedge clk);
                #1;
                forcedReady = 1'b1;
            end
        join
        idleReq();
        repeat (5) @(posedge clk);
        #1;

        $display("[TB] read followed by same-address write");
        applyStimulus(1'b0, 3'd5, '0);
        applyStimulus(1'b1, 3'd5, 32'h1234_5678);
        applyStimulus(1'b0, 3'd5, '0);
        idleReq();
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] random traffic");
        rndReady = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                applyStimulus(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            end else begin
                idleReq();
                @(posedge clk);
                #1;
            end
        end
        idleReq();
        rndReady    = 1'b0;
        forcedReady = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("drained", DW'(expQ.size()), '0);

        $display("[TB] reset with two buffered responses");
        forcedReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'd1, '0);
        applyStimulus(1'b0, 3'd2, '0);
        idleReq();
        @(posedge clk);
        #3;
        monEn = 1'b0;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("run_reset");
        checkSweep(-1);
        monEn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] reset in the middle of the sweep");
        monEn = 1'b0;
        rst_n = 1'b0;
        #2;
        checkResetOutputs("pre_init_reset");
        checkSweep(4);
        checkSweep(-1);
        monEn = 1'b1;
        forcedReady = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'd3, '0);
        applyStimulus(1'b0, 3'd5, '0);
        idleReq();
        repeat (4) @(posedge clk);
        #1;
        checkOutput("final_drained", DW'(expQ.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_port_ctrl.md
BRAM_PORT_CTRL -- requirements
Module: bram_port_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the RAM word width.
REQ-002 SHALL have parameter DEPTH, default 512, meaning the RAM word count; ADDR_W = $clog2(DEPTH).
REQ-003 SHALL have ports: clk input 1 (clock); rst_n input 1 (asynchronous, active-low reset).
REQ-004 SHALL have ports: req_valid input 1; req_ready output 1; req_we input 1; req_addr input ADDR_W; req_wdata input DATA_WIDTH (client request channel).
REQ-005 SHALL have ports: rsp_valid output 1; rsp_ready input 1; rsp_data output DATA_WIDTH (read response channel).
REQ-006 SHALL have port init_done output 1, meaning the RAM sweep is complete.
REQ-007 SHALL have RAM-side ports: ram_en output 1; ram_we output 1; ram_addr output ADDR_W; ram_data_in output DATA_WIDTH; ram_data_out input DATA_WIDTH. These drive one port of a synchronous write-first RAM with 1-cycle read latency.

Function
REQ-008 SHALL implement FSM states IDLE, INIT and RUN, entering IDLE on reset.
- IDLE -> INIT after exactly one clock.
- INIT -> RUN after the write to address DEPTH-1.
- RUN holds until reset.
REQ-009 In IDLE, SHALL drive ram_en=0, req_ready=0 and rsp_valid=0.
REQ-010 In INIT, SHALL issue one write per cycle: ram_en=1, ram_we=1, ram_data_in=0, ram_addr = sweep counter counting 0..DEPTH-1; the sweep SHALL take exactly DEPTH cycles.
REQ-011 init_done SHALL be 0 in IDLE and INIT, and 1 in RUN.
REQ-012 In INIT, req_ready SHALL be 0 and requests SHALL be ignored.
REQ-013 In RUN, a request SHALL be accepted in cycle T when req_valid && req_ready.
- Same cycle: ram_en=1, ram_we=req_we, ram_addr=req_addr, ram_data_in=req_wdata (combinational pass-through).
- Without acceptance: ram_en=0.
REQ-014 An accepted write SHALL produce no response; an accepted read SHALL produce exactly one response, carrying the RAM word at req_addr as of cycle T.
REQ-015 SHALL contain a 2-entry response FIFO plus a read-in-flight flag; credits = FIFO occupancy + in-flight flag.
REQ-016 req_ready SHALL equal (state==RUN) && (credits < 2), computed from registered state only (no combinational path from rsp_ready or req_valid).
REQ-017 In cycle T+1 after a read, ram_data_out is valid; handling depends on FIFO state.
- FIFO empty: SHALL bypass, with rsp_valid=1 and rsp_data=ram_data_out. If rsp_ready=0, the word SHALL be pushed into the FIFO.
- FIFO non-empty: rsp_data SHALL be the FIFO head, and the arriving word SHALL be pushed behind it.
REQ-018 rsp_valid SHALL be (FIFO non-empty) || (read in flight); a response SHALL pop on rsp_valid && rsp_ready.
REQ-019 Simultaneous push and pop SHALL keep occupancy unchanged.
REQ-020 FIFO pointers SHALL wrap modulo 2; overflow SHALL be impossible by REQ-016.
REQ-021 Once rsp_valid is asserted, rsp_data SHALL stay stable until popped.
REQ-022 Responses SHALL return in request order.
REQ-023 Back-to-back reads SHALL sustain 1 per cycle while rsp_ready=1.
REQ-024 A write accepted in the cycle after a read to the same address SHALL NOT alter that read's response.
REQ-025 Writes SHALL be accepted under the same credit rule as reads, even though they consume no credit after acceptance.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously force:
- state=IDLE, sweep counter=0;
- FIFO empty, in-flight flag=0;
- req_ready=0, rsp_valid=0, init_done=0;
- ram_en=0, ram_we=0, ram_addr=0, ram_data_in=0, rsp_data=0.
REQ-027 Reset asserted mid-INIT or mid-RUN SHALL discard all pending responses; after release, the block SHALL restart from IDLE and repeat the full sweep.

Verification (DEPTH=8, DATA_WIDTH=32)
REQ-028 Release reset -> 1 IDLE cycle, then 8 cycles with ram_we=1 at addr 0..7 and data 0; init_done=1 on the next cycle, along with req_ready=1.
REQ-029 After init, write 0xDEADBEEF to addr 3, then read addr 3 with rsp_ready=1 -> rsp_valid=1 one cycle after read acceptance, rsp_data=0xDEADBEEF; no response for the write.
REQ-030 Reads of addr 1,2,3 issued back-to-back with rsp_ready=0 -> only 2 accepted (req_ready drops); raise rsp_ready -> responses for addr 1, 2, 3 return in order, with data held stable while stalled.
REQ-031 Read addr 5 (value 0) then, the next cycle, write 0x12345678 to addr 5 -> response=0x00000000; a later read of addr 5 returns 0x12345678.
REQ-032 Assert rst_n=0 during INIT at counter=4, and separately with 2 buffered responses in RUN -> outputs clear immediately; after release, rsp_valid stays 0 and a full 8-cycle sweep reruns.
